// File: rtl/flag_branch_unit.sv
// flag_branch_unit
// Holds the architectural {Z,V,N} flags written by the EX stage and resolves
// conditional branches against them. Resolution waits while a flag producer in
// EX has not yet committed.
//
// Optional feature: define FLAG_BYPASS_EN to forward a committing producer's
// flags straight into branch evaluation. This removes the wait cycle for a
// producer in the same cycle. A stalled producer still blocks the branch.
//
// state | meaning
// IDLE  | no branch in flight; a presented branch is evaluated this cycle
// WAIT  | branch held (br_stall=1) until the flag hazard or flush clears
// DONE  | one-cycle result: br_done=1, br_taken holds the registered decision

module flag_branch_unit #(
    // Reset value of taken_cnt (normally zero)
    parameter logic [15:0] TAKEN_CNT_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [2:0]  ex_flags,
    input  logic        ex_stall,
    input  logic        ex_flush,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    output logic        br_done,
    output logic        br_taken,
    output logic        br_stall,
    output logic [2:0]  flags_q,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [2:0]  wr_mask;
    logic        ex_writes;
    logic        wr_commit;
    logic [2:0]  flags_next;
    logic [2:0]  eff_flags;
    logic        hazard;
    logic        blocked;
    logic        taken_q;

    // Flag bits are ordered {Z,V,N}. Z is bit 2, V is bit 1, N is bit 0.
    function automatic logic cond_taken(input logic [2:0] cond, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (cond)
            3'b000:  cond_taken = ~z;
            3'b001:  cond_taken = z;
            3'b010:  cond_taken = ~z & ~n;
            3'b011:  cond_taken = n;
            3'b100:  cond_taken = z | (~z & ~n);
            3'b101:  cond_taken = n | z;
            3'b110:  cond_taken = v;
            default: cond_taken = 1'b1;
        endcase
    endfunction

    // Decode which flags the EX opcode writes
    always_comb begin
        wr_mask = 3'b000;
        case (ex_opcode)
            4'b0000, 4'b0001:                     wr_mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110:   wr_mask = 3'b100;
            default:                              wr_mask = 3'b000;
        endcase
    end

    assign ex_writes  = |wr_mask;
    // A flush kills the write even when the pipeline is also stalled.
    assign wr_commit  = ex_valid & ~ex_stall & ~ex_flush & ex_writes;
    assign flags_next = (flags_q & ~wr_mask) | (ex_flags & wr_mask);

`ifdef FLAG_BYPASS_EN
    assign eff_flags = wr_commit ? flags_next : flags_q;
    assign hazard    = ex_valid & ~ex_flush & ex_writes & ex_stall;
`else
    assign eff_flags = flags_q;
    assign hazard    = ex_valid & ~ex_flush & ex_writes;
`endif

    // A flush cycle is never used for evaluation, so a killed write is never observed.
    assign blocked = hazard | ex_flush;

    // Next-state logic for the branch resolution FSM
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (br_valid) begin
                    next_state = blocked ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (!br_valid) begin
                    next_state = IDLE;
                end else if (!blocked) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and decision capture on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            taken_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == DONE) begin
                taken_q <= cond_taken(br_cond, eff_flags);
            end
        end
    end

    // Architectural flags update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (wr_commit) begin
            flags_q <= flags_next;
        end
    end

    // Count taken branches as their result leaves DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= TAKEN_CNT_RST;
        end else if (state == DONE && taken_q) begin
            taken_cnt <= taken_cnt + 16'd1;
        end
    end

    // The outputs decode the registered state only, so no path runs from ex_* to br_stall.
    assign br_done  = (state == DONE);
    assign br_stall = (state == WAIT);
    assign br_taken = taken_q;

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_opcode  in  4  EX-stage opcode, same encoding as the ALU opcode.
- ex_flags  in  3  ALU flagsOut, ordered {Z,V,N}.
- ex_stall  in  1  pipeline holds EX this cycle.
- ex_flush  in  1  kill EX-stage instruction.
- br_valid  in  1  decode presents a branch; held until br_done.
- br_cond  in  3  condition code; stable while br_valid.
- br_done  out  1  one-cycle pulse; the decision is valid this cycle.
- br_taken  out  1  decision; meaningful only when br_done=1.
- br_stall  out  1  decode must hold the branch.
- flags_q  out  3  architectural {Z,V,N}.
- taken_cnt  out  16  count of taken branches.

Function
REQ-002 Flag write enables SHALL be decoded from ex_opcode as follows:
- 0000, 0001: write Z, V, N.
- 0010, 0100, 0101, 0110: write Z only; V and N retained.
- All other opcodes: no write.
REQ-003 A flag write SHALL commit at the clock edge when ex_valid=1, ex_stall=0 and ex_flush=0; otherwise flags_q SHALL hold.
REQ-004 ex_flush SHALL override ex_stall, so that no write occurs.
REQ-005 Condition evaluation SHALL use effective flags F as follows:
- 000: taken when Z=0.
- 001: taken when Z=1.
- 010: taken when Z=0 and N=0.
- 011: taken when N=1.
- 100: taken when Z=1, or when Z=0 and N=0.
- 101: taken when N=1 or Z=1.
- 110: taken when V=1.
- 111: always taken.
REQ-006 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-007 In IDLE with br_valid=1: if no hazard applies, the FSM SHALL go to DONE; otherwise it SHALL go to WAIT with br_stall=1.
REQ-008 A hazard SHALL be defined as ex_valid=1, ex_flush=0 and ex_opcode writes any flag, where bypass is not permitted by REQ-020 or ex_stall=1.
REQ-009 In WAIT, the FSM SHALL stay while the hazard persists and go to DONE once it clears; br_stall SHALL remain 1 throughout WAIT.
REQ-010 DONE SHALL last exactly one cycle: br_done=1, br_taken evaluated per REQ-005, br_stall=0; the next state SHALL be IDLE.
REQ-011 The minimum latency from br_valid rising to br_done SHALL be 1 cycle.
REQ-012 Back-to-back branches SHALL each take at least 2 cycles, because of the IDLE revisit.
REQ-013 The decision SHALL be registered at entry to DONE from the F of that cycle, and SHALL NOT be re-evaluated in DONE.
REQ-014 If br_valid drops while in WAIT, the FSM SHALL return to IDLE with no br_done; this is treated as a decode-side squash.
REQ-015 taken_cnt SHALL increment by 1 on each br_done with br_taken=1, and SHALL wrap from FFFF to 0000.
REQ-016 A branch SHALL NOT be evaluated while ex_flush=1, so a killed write is never seen; a flush during WAIT clears the hazard next evaluation.
REQ-017 br_stall SHALL be registered, with no combinational path from ex_* inputs to br_stall.

Reset
REQ-018 Reset SHALL be asynchronous, asserted while rst_n=0, and released synchronously to clk.
REQ-019 Reset values SHALL be: FSM=IDLE, flags_q=000, br_done=0, br_taken=0, br_stall=0, taken_cnt=0000. Reset asserted mid-WAIT SHALL abandon the branch with no br_done.

Configuration
REQ-020 Macro FLAG_BYPASS_EN SHALL control flag bypassing.
- Defined: F merges ex_flags over flags_q under the REQ-002 mask when a write qualifies per REQ-003, so a same-cycle producer resolves with no WAIT.
- Undefined: F=flags_q always, and any qualifying producer in EX is a hazard, costing 1 WAIT cycle.

Verification
REQ-021 Reset check: rst_n=0 mid-WAIT, then release -> flags_q=000, taken_cnt=0, br_done stays 0 for 3 cycles with br_valid=0.
REQ-022 SUB producer: ex_opcode=0001, ex_flags=100 committed; then branch br_cond=001 -> br_done with br_taken=1; flags_q=100; taken_cnt=1.
REQ-023 Partial write: flags_q=011; XOR (0010) with ex_flags=100 committed -> flags_q=111.
REQ-024 Same-cycle producer: ADD with ex_flags=001 alongside branch br_cond=011.
- With FLAG_BYPASS_EN: br_done after 1 cycle, taken=1.
- Without it: br_stall=1 for 1 cycle, then br_done, taken=1.
REQ-025 Stall and flush: producer held by ex_stall=1 for 3 cycles -> br_stall=1 throughout; ex_flush on cycle 4 -> flags_q unchanged, branch resolves from the old flags.
REQ-026 Counter wrap: preset taken_cnt=FFFF via 65535 taken branches with br_cond=111, then one more -> taken_cnt=0000.
